// File: rtl/match_pkg.sv
// Shared types and default geometry for the memory-match turn controller.
// Provides the turn state enum, tile/symbol sizing and a symbol extractor.
package match_pkg;

   localparam int NTILES = 16;
   localparam int SYM_W  = 3;
   localparam int IDX_W  = $clog2(NTILES);

   typedef enum logic [2:0] {
      PICK1,
      PICK2,
      COMPARE,
      SHOW,
      DONE
   } state_e;

   function automatic logic [SYM_W-1:0] sym_at(
      input logic [NTILES*SYM_W-1:0] tiles,
      input logic [IDX_W-1:0]        idx
   );
      return tiles[int'(idx)*SYM_W +: SYM_W];
   endfunction

endpackage

// File: rtl/match_hold_timer.sv
// Loadable down-counter that stops at zero.
// Ports: clk, reset, load_i/load_val_i (load), en_i (decrement), value_o, zero_o.
module match_hold_timer #(
   parameter int W = 10
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         load_i,
   input  logic [W-1:0] load_val_i,
   input  logic         en_i,
   output logic [W-1:0] value_o,
   output logic         zero_o
);

   logic [W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load_i)
         cnt_d = load_val_i;
      else if (en_i && cnt_q != '0)
         cnt_d = cnt_q - 1'b1;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) cnt_q <= '0;
      else       cnt_q <= cnt_d;
   end

   assign value_o = cnt_q;
   assign zero_o  = (cnt_q == '0);

endmodule

// File: rtl/match_turn_ctrl.sv
// Two-player turn sequencer for the memory match game: accepts picks,
// compares symbols, holds mismatches visible, tracks masks, player, scores.
// Ports: clk, reset (async, high), sel_valid/sel_idx/sel_ready pick handshake,
// tiles symbol bus, revealed/matched masks, player, score0/1, match/miss
// strobes, game_over. Optional macro TURN_TIMEOUT_EN adds an idle-pick timeout.
module match_turn_ctrl
   import match_pkg::*;
#(
   parameter int NTILES         = match_pkg::NTILES,
   parameter int SYM_W          = match_pkg::SYM_W,
   parameter int SHOW_CYCLES    = 1000,
   parameter int SCORE_W        = 4,
   parameter int TIMEOUT_CYCLES = 5000
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    sel_valid,
   input  logic [$clog2(NTILES)-1:0] sel_idx,
   output logic                    sel_ready,
   input  logic [NTILES*SYM_W-1:0] tiles,
   output logic [NTILES-1:0]       revealed,
   output logic [NTILES-1:0]       matched,
   output logic                    player,
   output logic [SCORE_W-1:0]      score0,
   output logic [SCORE_W-1:0]      score1,
   output logic                    match_pulse,
   output logic                    miss_pulse,
   output logic                    game_over
);

   localparam int LIDX_W = $clog2(NTILES);
   localparam int TMAX   = (SHOW_CYCLES > TIMEOUT_CYCLES) ?
                           SHOW_CYCLES : TIMEOUT_CYCLES;
   localparam int TW     = $clog2(TMAX + 1);
   localparam logic [NTILES-1:0] ONE = NTILES'(1);

   state_e                state_q, state_d;
   logic [NTILES-1:0]     revealed_q, revealed_d;
   logic [NTILES-1:0]     matched_q, matched_d;
   logic                  player_q, player_d;
   logic [SCORE_W-1:0]    score0_q, score0_d;
   logic [SCORE_W-1:0]    score1_q, score1_d;
   logic [LIDX_W-1:0]     first_q, first_d;
   logic [LIDX_W-1:0]     second_q, second_d;
   logic                  mpulse_q, mpulse_d;
   logic                  xpulse_q, xpulse_d;

   logic                  tmr_load, tmr_en, tmr_zero;
   logic [TW-1:0]         tmr_load_val, tmr_val;
   logic                  accept;
   logic [NTILES-1:0]     pair;

`ifdef TURN_TIMEOUT_EN
   // Timer reads 0 out of reset; the first PICK cycle arms it instead of
   // treating that 0 as an expired idle window.
   logic armed_q, armed_d;
`endif

   // SHOW hold and idle timeout share one counter: their states never overlap.
   match_hold_timer #(.W(TW)) u_timer (
      .clk        (clk),
      .reset      (reset),
      .load_i     (tmr_load),
      .load_val_i (tmr_load_val),
      .en_i       (tmr_en),
      .value_o    (tmr_val),
      .zero_o     (tmr_zero)
   );

   assign sel_ready = !reset && (state_q == PICK1 || state_q == PICK2);
   // Already-revealed covers re-picking the first tile during PICK2.
   assign accept = sel_valid && sel_ready &&
                   !matched_q[sel_idx] && !revealed_q[sel_idx];
   assign pair   = (ONE << first_q) | (ONE << second_q);

   always_comb begin
      state_d      = state_q;
      revealed_d   = revealed_q;
      matched_d    = matched_q;
      player_d     = player_q;
      score0_d     = score0_q;
      score1_d     = score1_q;
      first_d      = first_q;
      second_d     = second_q;
      mpulse_d     = 1'b0;
      xpulse_d     = 1'b0;
      tmr_load     = 1'b0;
      tmr_load_val = '0;
      tmr_en       = 1'b0;
`ifdef TURN_TIMEOUT_EN
      armed_d      = armed_q;
`endif
      unique case (state_q)
         PICK1: begin
            if (accept) begin
               revealed_d[sel_idx] = 1'b1;
               first_d             = sel_idx;
               state_d             = PICK2;
            end
         end
         PICK2: begin
            if (accept) begin
               revealed_d[sel_idx] = 1'b1;
               second_d            = sel_idx;
               state_d             = COMPARE;
            end
         end
         COMPARE: begin
            if (sym_at(tiles, first_q) == sym_at(tiles, second_q)) begin
               matched_d  = matched_q | pair;
               revealed_d = revealed_q & ~pair;
               mpulse_d   = 1'b1;
               if (!player_q && score0_q != '1)
                  score0_d = score0_q + 1'b1;
               if (player_q && score1_q != '1)
                  score1_d = score1_q + 1'b1;
               state_d = (&matched_d) ? DONE : PICK1;
            end else begin
               xpulse_d     = 1'b1;
               tmr_load     = 1'b1;
               tmr_load_val = TW'(SHOW_CYCLES - 1);
               state_d      = SHOW;
            end
         end
         SHOW: begin
            tmr_en = |tmr_val;
            if (tmr_zero) begin
               revealed_d = '0;
               player_d   = ~player_q;
               state_d    = PICK1;
            end
         end
         DONE: begin
         end
         default: state_d = PICK1;
      endcase
`ifdef TURN_TIMEOUT_EN
      if (state_q == PICK1 || state_q == PICK2) begin
         if (accept || !armed_q) begin
            tmr_load     = 1'b1;
            tmr_load_val = TW'(TIMEOUT_CYCLES - 1);
            armed_d      = 1'b1;
         end else if (tmr_zero) begin
            revealed_d   = '0;
            player_d     = ~player_q;
            xpulse_d     = 1'b1;
            state_d      = PICK1;
            tmr_load     = 1'b1;
            tmr_load_val = TW'(TIMEOUT_CYCLES - 1);
         end else begin
            tmr_en = 1'b1;
         end
      end else if (state_d == PICK1) begin
         tmr_load     = 1'b1;
         tmr_load_val = TW'(TIMEOUT_CYCLES - 1);
      end
`endif
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= PICK1;
         revealed_q <= '0;
         matched_q  <= '0;
         player_q   <= 1'b0;
         score0_q   <= '0;
         score1_q   <= '0;
         first_q    <= '0;
         second_q   <= '0;
         mpulse_q   <= 1'b0;
         xpulse_q   <= 1'b0;
`ifdef TURN_TIMEOUT_EN
         armed_q    <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         revealed_q <= revealed_d;
         matched_q  <= matched_d;
         player_q   <= player_d;
         score0_q   <= score0_d;
         score1_q   <= score1_d;
         first_q    <= first_d;
         second_q   <= second_d;
         mpulse_q   <= mpulse_d;
         xpulse_q   <= xpulse_d;
`ifdef TURN_TIMEOUT_EN
         armed_q    <= armed_d;
`endif
      end
   end

   assign revealed    = revealed_q;
   assign matched     = matched_q;
   assign player      = player_q;
   assign score0      = score0_q;
   assign score1      = score1_q;
   assign match_pulse = mpulse_q;
   assign miss_pulse  = xpulse_q;
   assign game_over   = (state_q == DONE);

endmodule

// File: tb/tb_match_turn_ctrl.sv
// Self-checking bench for match_turn_ctrl: scoreboard of expected outcomes
// per pick pair, popped when a match/miss strobe appears.
module tb_match_turn_ctrl;

   localparam int SC = 20;
   localparam int TC = 40;

   typedef struct packed {
      logic        is_match;
      logic [15:0] matched;
      logic [15:0] revealed;
      logic [3:0]  s0;
      logic [3:0]  s1;
      logic        pl;
   } exp_t;

   logic        clk;
   logic        reset;
   logic        sel_valid;
   logic [3:0]  sel_idx;
   logic        sel_ready;
   logic [47:0] tiles;
   logic [15:0] revealed;
   logic [15:0] matched;
   logic        player;
   logic [3:0]  score0;
   logic [3:0]  score1;
   logic        match_pulse;
   logic        miss_pulse;
   logic        game_over;

   logic [2:0]  sym [16];
   logic [15:0] m_matched;
   logic [3:0]  m_s0, m_s1;
   logic        m_pl;
   exp_t        q [$];
   int          checks;
   int          errors;

   match_turn_ctrl #(
      .SHOW_CYCLES    (SC),
      .TIMEOUT_CYCLES (TC)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .sel_valid   (sel_valid),
      .sel_idx     (sel_idx),
      .sel_ready   (sel_ready),
      .tiles       (tiles),
      .revealed    (revealed),
      .matched     (matched),
      .player      (player),
      .score0      (score0),
      .score1      (score1),
      .match_pulse (match_pulse),
      .miss_pulse  (miss_pulse),
      .game_over   (game_over)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always_comb begin
      tiles = '0;
      for (int k = 0; k < 16; k++)
         tiles[k*3 +: 3] = sym[k];
   end

   // Scoreboard consumer: every strobe must match the oldest expectation.
   always @(negedge clk) begin
      exp_t e;
      exp_t g;
      if (!reset && (match_pulse || miss_pulse)) begin
         checks++;
         if (q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_pulse got match=%0b miss=%0b want none",
                     match_pulse, miss_pulse);
         end else begin
            e = q.pop_front();
            g = {match_pulse, matched, revealed, score0, score1, player};
            if ({g, match_pulse ^ miss_pulse} !== {e, 1'b1}) begin
               errors++;
               $display("FAIL outcome got %h miss=%0b want %h",
                        g, miss_pulse, e);
            end
         end
      end
   end

   task automatic model_reset();
      m_matched = '0;
      m_s0 = '0;
      m_s1 = '0;
      m_pl = 1'b0;
      q.delete();
   endtask

   task automatic do_pick(input int idx);
      sel_idx   = idx[3:0];
      sel_valid = 1'b1;
      @(posedge clk);
      #1;
      sel_valid = 1'b0;
   endtask

   task automatic play_pair(input int a, input int b,
                            input bit first_done, input bit poke);
      logic [15:0] bits;
      bit          eq;
      bit          bad;
      int          n;
      exp_t        e;
      bits = (16'h1 << a) | (16'h1 << b);
      eq   = (sym[a] == sym[b]);
      if (eq) begin
         m_matched = m_matched | bits;
         if (m_pl) m_s1 = m_s1 + 1'b1;
         else      m_s0 = m_s0 + 1'b1;
         e = {1'b1, m_matched, 16'h0, m_s0, m_s1, m_pl};
      end else begin
         e = {1'b0, m_matched, bits, m_s0, m_s1, m_pl};
      end
      q.push_back(e);
      if (!first_done) do_pick(a);
      do_pick(b);
      checks++;
      if (match_pulse !== 1'b0 || miss_pulse !== 1'b0 || revealed !== bits) begin
         errors++;
         $display("FAIL compare_cycle got mp=%0b xp=%0b rev=%h want 0 0 %h",
                  match_pulse, miss_pulse, revealed, bits);
      end
      @(posedge clk);
      #1;
      checks++;
      if ({match_pulse, miss_pulse} !== (eq ? 2'b10 : 2'b01)) begin
         errors++;
         $display("FAIL pulse_latency got %b want %b",
                  {match_pulse, miss_pulse}, eq ? 2'b10 : 2'b01);
      end
      if (!eq) begin
         n   = 0;
         bad = 1'b0;
         if (poke) begin
            sel_idx   = 4'd7;
            sel_valid = 1'b1;
         end
         while (sel_ready !== 1'b1 && n < 4 * SC) begin
            if (revealed !== bits) bad = 1'b1;
            @(posedge clk);
            #1;
            n++;
            if (n == 3) sel_valid = 1'b0;
         end
         sel_valid = 1'b0;
         m_pl = ~m_pl;
         checks++;
         if (n != SC || bad) begin
            errors++;
            $display("FAIL show_hold got cycles=%0d bad=%0b want %0d 0",
                     n, bad, SC);
         end
         checks++;
         if (revealed !== 16'h0 || player !== m_pl) begin
            errors++;
            $display("FAIL show_end got rev=%h pl=%0b want 0 %0b",
                     revealed, player, m_pl);
         end
      end
   endtask

   task automatic test_reset();
      #12;
      checks++;
      if ({sel_ready, revealed, matched, player, score0, score1,
           match_pulse, miss_pulse, game_over} !== '0) begin
         errors++;
         $display("FAIL reset_outputs got rdy=%0b rev=%h mat=%h want all 0",
                  sel_ready, revealed, matched);
      end
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk);
      #1;
      checks++;
      if (sel_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_release got rdy=%0b want 1", sel_ready);
      end
   endtask

   task automatic test_match();
      play_pair(0, 5, 1'b0, 1'b0);
      checks++;
      if (matched !== 16'h0021 || score0 !== 4'd1 || player !== 1'b0) begin
         errors++;
         $display("FAIL match_state got mat=%h s0=%0d pl=%0b want 0021 1 0",
                  matched, score0, player);
      end
   endtask

   task automatic test_mismatch();
      play_pair(1, 2, 1'b0, 1'b1);
      checks++;
      if (player !== 1'b1 || score0 !== 4'd1 || score1 !== 4'd0) begin
         errors++;
         $display("FAIL mismatch_state got pl=%0b s0=%0d s1=%0d want 1 1 0",
                  player, score0, score1);
      end
   endtask

   task automatic test_illegal();
      do_pick(0);
      checks++;
      if (sel_ready !== 1'b1 || revealed !== 16'h0) begin
         errors++;
         $display("FAIL pick_matched got rdy=%0b rev=%h want 1 0000",
                  sel_ready, revealed);
      end
      do_pick(3);
      do_pick(3);
      checks++;
      if (sel_ready !== 1'b1 || revealed !== 16'h0008) begin
         errors++;
         $display("FAIL repick_first got rdy=%0b rev=%h want 1 0008",
                  sel_ready, revealed);
      end
      play_pair(3, 10, 1'b1, 1'b0);
      checks++;
      if (score1 !== 4'd1 || player !== 1'b1) begin
         errors++;
         $display("FAIL p1_match got s1=%0d pl=%0b want 1 1", score1, player);
      end
   endtask

   task automatic test_full_game();
      int pa [6] = '{1, 2, 4, 6, 7, 14};
      int pb [6] = '{8, 9, 11, 12, 13, 15};
      for (int i = 0; i < 6; i++) begin
         if (i < 5) play_pair(pa[i], pa[i+1], 1'b0, 1'b0);
         play_pair(pa[i], pb[i], 1'b0, 1'b0);
      end
      #1;
      checks++;
      if (game_over !== 1'b1 || sel_ready !== 1'b0 ||
          matched !== 16'hFFFF) begin
         errors++;
         $display("FAIL game_over got go=%0b rdy=%0b mat=%h want 1 0 ffff",
                  game_over, sel_ready, matched);
      end
      checks++;
      if (5'(score0) + 5'(score1) !== 5'd8) begin
         errors++;
         $display("FAIL score_sum got %0d want 8", score0 + score1);
      end
      sel_idx   = 4'd1;
      sel_valid = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      sel_valid = 1'b0;
      checks++;
      if ({game_over, player, score0, score1, revealed} !==
          {1'b1, m_pl, m_s0, m_s1, 16'h0}) begin
         errors++;
         $display("FAIL done_frozen got go=%0b pl=%0b s0=%0d s1=%0d want 1 %0b %0d %0d",
                  game_over, player, score0, score1, m_pl, m_s0, m_s1);
      end
   endtask

   task automatic test_reset_mid_show();
      exp_t e;
      reset = 1'b1;
      #7;
      reset = 1'b0;
      model_reset();
      @(posedge clk);
      #1;
      e = {1'b0, 16'h0, 16'h0006, 4'd0, 4'd0, 1'b0};
      q.push_back(e);
      do_pick(1);
      do_pick(2);
      repeat (11) @(posedge clk);
      #3;
      checks++;
      if (revealed !== 16'h0006 || sel_ready !== 1'b0) begin
         errors++;
         $display("FAIL pre_reset_show got rev=%h rdy=%0b want 0006 0",
                  revealed, sel_ready);
      end
      reset = 1'b1;
      #1;
      checks++;
      if ({sel_ready, revealed, matched, player, score0, score1,
           match_pulse, miss_pulse, game_over} !== '0) begin
         errors++;
         $display("FAIL async_reset got rev=%h mat=%h pl=%0b want all 0",
                  revealed, matched, player);
      end
      @(posedge clk);
      #2;
      reset = 1'b0;
      model_reset();
      @(posedge clk);
      #1;
      checks++;
      if (sel_ready !== 1'b1 || revealed !== 16'h0 || player !== 1'b0) begin
         errors++;
         $display("FAIL post_reset got rdy=%0b rev=%h pl=%0b want 1 0 0",
                  sel_ready, revealed, player);
      end
      play_pair(0, 5, 1'b0, 1'b0);
      checks++;
      if (score0 !== 4'd1 || matched !== 16'h0021) begin
         errors++;
         $display("FAIL post_reset_match got s0=%0d mat=%h want 1 0021",
                  score0, matched);
      end
   endtask

`ifdef TURN_TIMEOUT_EN
   task automatic test_timeout();
      exp_t e;
      int   n;
      e = {1'b0, m_matched, 16'h0, m_s0, m_s1, ~m_pl};
      q.push_back(e);
      do_pick(4);
      n = 0;
      while (q.size() != 0 && n < 3 * TC) begin
         @(posedge clk);
         #1;
         n++;
      end
      m_pl = ~m_pl;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (q.size() != 0 || revealed !== 16'h0 || player !== m_pl) begin
         errors++;
         $display("FAIL timeout got pend=%0d rev=%h pl=%0b want 0 0 %0b",
                  q.size(), revealed, player, m_pl);
      end
   endtask
`endif

   initial begin
      checks    = 0;
      errors    = 0;
      reset     = 1'b1;
      sel_valid = 1'b0;
      sel_idx   = '0;
      sym = '{3'd2, 3'd1, 3'd4, 3'd0, 3'd3, 3'd2, 3'd5, 3'd6,
              3'd1, 3'd4, 3'd0, 3'd3, 3'd5, 3'd6, 3'd7, 3'd7};
      model_reset();
      test_reset();
      test_match();
      test_mismatch();
      test_illegal();
      test_full_game();
      test_reset_mid_show();
`ifdef TURN_TIMEOUT_EN
      test_timeout();
`endif
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL pending_expectations got %0d want 0", q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
